match_sequencer: RTL and testbench

- Match-level controller that sequences the pong game datapath.
- It decides when the ball-and-pad logic runs, when a serve is issued and in which direction, keeps both scores, and declares the winner.
- Sits between the player start/pause inputs and the game-logic block. The game-logic block consumes game_run, serve_req and serve_dir, and reports misses via miss_left and miss_right.
- All timing is counted in game ticks, one per tick strobe.

---
 rtl/match_sequencer_pkg.sv | 37 +++
 rtl/match_sequencer_tick_countdown.sv | 50 +++++
 rtl/match_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_match_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_sequencer_pkg.sv
// match_sequencer_pkg
// Shared constants for the pong match controller: FSM state encodings,
// winner codes, serve direction values, default match timing and a
// saturating score increment helper.
// Optional feature macro used by importers: MATCH_PAUSE_EN (adds PAUSED).
package match_sequencer_pkg;

  // FSM state encodings. These values are visible on state_o.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SERVE  = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_POINT  = 3'd3;
  localparam logic [2:0] ST_OVER   = 3'd4;
  localparam logic [2:0] ST_PAUSED = 3'd5;

  // Winner codes.
  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // Serve direction: which player the ball travels toward.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Default match timing, in game ticks.
  localparam int DEF_WIN_SCORE   = 9;
  localparam int DEF_SERVE_TICKS = 60;
  localparam int DEF_POINT_TICKS = 90;
  localparam int DEF_CNT_W       = 8;

  // Score increment that never passes the winning score.
  function automatic logic [3:0] sat_inc(input logic [3:0] score,
                                         input logic [3:0] limit);
    return (score >= limit) ? score : score + 4'd1;
  endfunction

endpackage

// File: rtl/match_sequencer_tick_countdown.sv
// tick_countdown
// Loadable down-counter that decrements once per game tick while enabled.
// done_o is combinational and marks the tick that moves the count 1->0, so
// the owner can change state on that very clock edge.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   en_i           counting allowed (owner is in a timed state)
//   tick_i         game-rate strobe
//   load_i         load load_value_i (takes priority over counting)
//   load_value_i   reload value
//   done_o         high in the clk whose edge takes the count 1->0
module tick_countdown
  import match_sequencer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign done_o = en_i && tick_i && (count_q == CNT_W'(1));

  // Next count: a load wins over a decrement; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (en_i && tick_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer
// Match-level controller for the pong datapath: gates ball/pad updates,
// issues serves with a direction, keeps both scores and declares a winner.
// Optional feature: define MATCH_PAUSE_EN to add the pause input and the
// PAUSED state (toggled by rising edges of pause while playing).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   tick                     one-clk game-rate strobe
//   start                    level; starts a match (rising edge in OVER)
//   miss_left, miss_right    one-clk miss pulses from the game logic
//   random                   random bit for the opening serve direction
//   pause (optional)         level; rising edges pause/resume play
//   game_run                 enable for ball/pad update
//   serve_req                one-clk serve pulse
//   serve_dir                0 toward left player, 1 toward right player
//   score_left, score_right  4-bit scores
//   winner                   00 none, 01 left, 10 right
//   state_o                  encoded FSM state
module match_sequencer
  import match_sequencer_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int POINT_TICKS = DEF_POINT_TICKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       random,
`ifdef MATCH_PAUSE_EN
  input  logic       pause,
`endif
  output logic       game_run,
  output logic       serve_req,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  localparam logic [3:0]       WIN_LIMIT  = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_TICKS);

  logic [2:0]       state_q, state_d;
  logic             serve_dir_q, serve_dir_d;
  logic [3:0]       score_left_q, score_left_d;
  logic [3:0]       score_right_q, score_right_d;
  logic [1:0]       winner_q, winner_d;
  logic             serve_req_q, serve_req_d;
  logic             game_run_q;
  logic             start_prev_q;
  logic             start_rise;
  logic             begin_match;
  logic             cnt_en;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_done;

  assign start_rise = start && !start_prev_q;

  // IDLE starts on the start level; OVER needs a fresh edge so a start
  // held from the previous match cannot restart it.
  assign begin_match = (state_q == ST_IDLE) ? start : start_rise;

  assign cnt_en = (state_q == ST_SERVE) || (state_q == ST_POINT);

`ifdef MATCH_PAUSE_EN
  logic pause_prev_q;
  logic pause_rise;

  assign pause_rise = pause && !pause_prev_q;

  // Previous pause level for the rising-edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_prev_q <= 1'b0;
    end else begin
      pause_prev_q <= pause;
    end
  end
`endif

  // Shared countdown for the SERVE and POINT holds.
  tick_countdown #(
    .CNT_W(CNT_W)
  ) u_countdown (
    .clk         (clk),
    .rst         (rst),
    .en_i        (cnt_en),
    .tick_i      (tick),
    .load_i      (cnt_load),
    .load_value_i(cnt_load_value),
    .done_o      (cnt_done)
  );

  // Match FSM: next state, scores, serve direction, winner and serve pulse.
  always_comb begin
    state_d        = state_q;
    serve_dir_d    = serve_dir_q;
    score_left_d   = score_left_q;
    score_right_d  = score_right_q;
    winner_d       = winner_q;
    serve_req_d    = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = SERVE_LOAD;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (begin_match) begin
          state_d       = ST_SERVE;
          score_left_d  = 4'd0;
          score_right_d = 4'd0;
          winner_d      = WIN_NONE;
          serve_dir_d   = random;
          cnt_load      = 1'b1;
        end
      end

      ST_SERVE: begin
        if (cnt_done) begin
          state_d     = ST_PLAY;
          serve_req_d = 1'b1;
        end
      end

      ST_PLAY: begin
        // The loser of a point receives the next serve; a double miss is a
        // let that hands the serve to the other side.
        if (miss_left && miss_right) begin
          serve_dir_d    = !serve_dir_q;
          state_d        = ST_POINT;
          cnt_load       = 1'b1;
          cnt_load_value = POINT_LOAD;
        end else if (miss_left) begin
          score_right_d  = sat_inc(score_right_q, WIN_LIMIT);
          serve_dir_d    = DIR_LEFT;
          state_d        = ST_POINT;
          cnt_load       = 1'b1;
          cnt_load_value = POINT_LOAD;
        end else if (miss_right) begin
          score_left_d   = sat_inc(score_left_q, WIN_LIMIT);
          serve_dir_d    = DIR_RIGHT;
          state_d        = ST_POINT;
          cnt_load       = 1'b1;
          cnt_load_value = POINT_LOAD;
        end
`ifdef MATCH_PAUSE_EN
        else if (pause_rise) begin
          state_d = ST_PAUSED;
        end
`endif
      end

      ST_POINT: begin
        if (cnt_done) begin
          if (score_left_q == WIN_LIMIT) begin
            winner_d = WIN_LEFT;
            state_d  = ST_OVER;
          end else if (score_right_q == WIN_LIMIT) begin
            winner_d = WIN_RIGHT;
            state_d  = ST_OVER;
          end else begin
            state_d  = ST_SERVE;
            cnt_load = 1'b1;
          end
        end
      end

`ifdef MATCH_PAUSE_EN
      ST_PAUSED: begin
        if (pause_rise) begin
          state_d = ST_PLAY;
        end
      end
`else
      // Unreachable without the pause feature; recover to IDLE.
      ST_PAUSED: begin
        state_d = ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. game_run follows the registered state, so it
  // rises one clk after PLAY is entered and falls one clk after leaving it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      serve_dir_q   <= DIR_LEFT;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      winner_q      <= WIN_NONE;
      serve_req_q   <= 1'b0;
      game_run_q    <= 1'b0;
      start_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      serve_dir_q   <= serve_dir_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      winner_q      <= winner_d;
      serve_req_q   <= serve_req_d;
      game_run_q    <= (state_q == ST_PLAY);
      start_prev_q  <= start;
    end
  end

  assign game_run    = game_run_q;
  assign serve_req   = serve_req_q;
  assign serve_dir   = serve_dir_q;
  assign score_left  = score_left_q;
  assign score_right = score_right_q;
  assign winner      = winner_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer
// Directed bench for match_sequencer with default parameters
// (WIN_SCORE 9, SERVE_TICKS 60, POINT_TICKS 90). Ticks are strobed every
// other clk so tick gating is exercised. Define MATCH_PAUSE_EN to also
// cover the pause feature.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic       miss_left;
  logic       miss_right;
  logic       random;
`ifdef MATCH_PAUSE_EN
  logic       pause;
`endif
  logic       game_run;
  logic       serve_req;
  logic       serve_dir;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic [1:0] winner;
  logic [2:0] state_o;

  int nCompared   = 0;
  int nMismatched = 0;

  match_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .random     (random),
`ifdef MATCH_PAUSE_EN
    .pause      (pause),
`endif
    .game_run   (game_run),
    .serve_req  (serve_req),
    .serve_dir  (serve_dir),
    .score_left (score_left),
    .score_right(score_right),
    .winner     (winner),
    .state_o    (state_o)
  );

  // 10 ns clock.
  always #5 clk = !clk;

  // Safety net so the run always ends.
  initial begin
    #600000;
    $display("[TB] FAIL timeout: simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

  // Advance to 1 ns after the next rising edge; inputs set afterwards are
  // sampled on the following edge and outputs read here are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n tick strobes, each one clk high followed by one clk low.
  task automatic applyTicks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  // One miss pulse in PLAY followed by the full POINT hold.
  task automatic scorePoint(input logic ml, input logic mr);
    miss_left  = ml;
    miss_right = mr;
    step();
    miss_left  = 1'b0;
    miss_right = 1'b0;
    applyTicks(90);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick = 1'b0; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    random = 1'b0;
`ifdef MATCH_PAUSE_EN
    pause = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    step();
    nCompared++;
    if (state_o !== 3'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_state: got %0d expected 0", state_o);
    end
    nCompared++;
    if ({game_run, serve_req, serve_dir} !== 3'b000) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000", {game_run, serve_req, serve_dir});
    end
    nCompared++;
    if ({score_left, score_right, winner} !== 10'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_score: got %h expected 000", {score_left, score_right, winner});
    end
  endtask

  task automatic test_serve();
    random = 1'b1;
    start  = 1'b1;
    step();
    start  = 1'b0;
    nCompared++;
    if (state_o !== 3'd1 || serve_dir !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL start_serve: got state %0d dir %0d expected state 1 dir 1", state_o, serve_dir);
    end
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    nCompared++;
    if (score_right !== 4'd0 || state_o !== 3'd1) begin
      nMismatched++;
      $display("[TB] FAIL miss_in_serve: got score %0d state %0d expected 0 1", score_right, state_o);
    end
    applyTicks(59);
    nCompared++;
    if (state_o !== 3'd1 || serve_req !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL serve_59: got state %0d req %0d expected 1 0", state_o, serve_req);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    nCompared++;
    if (state_o !== 3'd2 || serve_req !== 1'b1 || game_run !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL serve_60: got state %0d req %0d run %0d expected 2 1 0", state_o, serve_req, game_run);
    end
    step();
    nCompared++;
    if (serve_req !== 1'b0 || game_run !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL serve_after: got req %0d run %0d expected 0 1", serve_req, game_run);
    end
  endtask

  task automatic test_miss_left();
    // Tick in the same clk as the miss must not matter.
    miss_left = 1'b1;
    tick      = 1'b1;
    step();
    miss_left = 1'b0;
    tick      = 1'b0;
    nCompared++;
    if (score_right !== 4'd1 || serve_dir !== 1'b0 || state_o !== 3'd3) begin
      nMismatched++;
      $display("[TB] FAIL miss_left: got score_r %0d dir %0d state %0d expected 1 0 3", score_right, serve_dir, state_o);
    end
    step();
    nCompared++;
    if (game_run !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL point_run: got %0d expected 0", game_run);
    end
    applyTicks(89);
    nCompared++;
    if (state_o !== 3'd3) begin
      nMismatched++;
      $display("[TB] FAIL point_89: got state %0d expected 3", state_o);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    nCompared++;
    if (state_o !== 3'd1 || serve_req !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL point_90: got state %0d req %0d expected 1 0", state_o, serve_req);
    end
    step();
    applyTicks(59);
    tick = 1'b1;
    step();
    tick = 1'b0;
    nCompared++;
    if (serve_req !== 1'b1 || state_o !== 3'd2) begin
      nMismatched++;
      $display("[TB] FAIL reserve: got req %0d state %0d expected 1 2", serve_req, state_o);
    end
    step();
  endtask

  task automatic test_let();
    // Left scores first so the serve points right before the let.
    scorePoint(1'b0, 1'b1);
    nCompared++;
    if (score_left !== 4'd1 || serve_dir !== 1'b1 || state_o !== 3'd1) begin
      nMismatched++;
      $display("[TB] FAIL miss_right: got score_l %0d dir %0d state %0d expected 1 1 1", score_left, serve_dir, state_o);
    end
    applyTicks(60);
    miss_left  = 1'b1;
    miss_right = 1'b1;
    step();
    miss_left  = 1'b0;
    miss_right = 1'b0;
    nCompared++;
    if (score_left !== 4'd1 || score_right !== 4'd1 || serve_dir !== 1'b0 || state_o !== 3'd3) begin
      nMismatched++;
      $display("[TB] FAIL let: got %0d-%0d dir %0d state %0d expected 1-1 0 3", score_left, score_right, serve_dir, state_o);
    end
    applyTicks(90);
    applyTicks(60);
  endtask

  task automatic test_win();
    for (int i = 0; i < 7; i++) begin
      scorePoint(1'b0, 1'b1);
      applyTicks(60);
    end
    nCompared++;
    if (score_left !== 4'd8 || game_run !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL left_8: got %0d run %0d expected 8 1", score_left, game_run);
    end
    miss_right = 1'b1;
    step();
    miss_right = 1'b0;
    nCompared++;
    if (score_left !== 4'd9 || state_o !== 3'd3 || winner !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL left_9: got %0d state %0d win %0d expected 9 3 0", score_left, state_o, winner);
    end
    // Held start through POINT is ignored and must not restart OVER later.
    start = 1'b1;
    applyTicks(90);
    nCompared++;
    if (state_o !== 3'd4 || winner !== 2'b01 || game_run !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL over: got state %0d win %0d run %0d expected 4 1 0", state_o, winner, game_run);
    end
    miss_right = 1'b1;
    step();
    miss_left  = 1'b1;
    miss_right = 1'b0;
    step();
    miss_left  = 1'b0;
    nCompared++;
    if (score_left !== 4'd9 || score_right !== 4'd1) begin
      nMismatched++;
      $display("[TB] FAIL over_hold: got %0d-%0d expected 9-1", score_left, score_right);
    end
  endtask

  task automatic test_restart();
    step(); step(); step();
    nCompared++;
    if (state_o !== 3'd4 || winner !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL held_start: got state %0d win %0d expected 4 1", state_o, winner);
    end
    start = 1'b0;
    step();
    random = 1'b0;
    start  = 1'b1;
    step();
    start  = 1'b0;
    nCompared++;
    if (state_o !== 3'd1 || score_left !== 4'd0 || score_right !== 4'd0 || winner !== 2'b00 || serve_dir !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL restart: got state %0d %0d-%0d win %0d dir %0d expected 1 0-0 0 0", state_o, score_left, score_right, winner, serve_dir);
    end
  endtask

  task automatic test_reset_midserve();
    random = 1'b1;
    applyTicks(59);
    tick = 1'b1;
    rst  = 1'b1;
    step();
    tick = 1'b0;
    nCompared++;
    if (serve_req !== 1'b0 || state_o !== 3'd0 || game_run !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rst_mid: got req %0d state %0d run %0d expected 0 0 0", serve_req, state_o, game_run);
    end
    step();
    rst = 1'b0;
    step(); step();
    nCompared++;
    if ({state_o, serve_req, serve_dir, score_left, score_right, winner} !== 15'd0) begin
      nMismatched++;
      $display("[TB] FAIL rst_after: got %h expected 0000", {state_o, serve_req, serve_dir, score_left, score_right, winner});
    end
  endtask

`ifdef MATCH_PAUSE_EN
  task automatic test_pause();
    start = 1'b1;
    step();
    start = 1'b0;
    applyTicks(60);
    pause = 1'b1;
    step();
    nCompared++;
    if (state_o !== 3'd5) begin
      nMismatched++;
      $display("[TB] FAIL pause_enter: got state %0d expected 5", state_o);
    end
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    nCompared++;
    if (game_run !== 1'b0 || score_right !== 4'd0 || state_o !== 3'd5) begin
      nMismatched++;
      $display("[TB] FAIL pause_hold: got run %0d score %0d state %0d expected 0 0 5", game_run, score_right, state_o);
    end
    pause = 1'b0;
    step();
    pause = 1'b1;
    step();
    nCompared++;
    if (state_o !== 3'd2 || serve_req !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL resume: got state %0d req %0d expected 2 0", state_o, serve_req);
    end
    step();
    nCompared++;
    if (game_run !== 1'b1 || serve_req !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL resume_run: got run %0d req %0d expected 1 0", game_run, serve_req);
    end
    pause = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_serve();
    test_miss_left();
    test_let();
    test_win();
    test_restart();
    test_reset_midserve();
`ifdef MATCH_PAUSE_EN
    test_pause();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
